// File: rtl/encoder_dataflow_sync_if.sv
// +--------------------------------------------------------------------+
// | encoder_dataflow_sync_if                                           |
// | Request lines and registered encoder results, grouped as one bus.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface encoder_dataflow_sync_if;
  logic       a;
  logic       b;
  logic       c;
  logic [1:0] outp;
  logic       valid;
  logic       multi;

  modport master (
    output a,
    output b,
    output c,
    input  outp,
    input  valid,
    input  multi
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output outp,
    output valid,
    output multi
  );
endinterface

`default_nettype wire

// File: rtl/encoder_dataflow_sync.sv
// +--------------------------------------------------------------------+
// | encoder_dataflow_sync                                              |
// | Registered 3-input priority encoder (a > b > c) with valid/multi.  |
// | Optional macro ENCODER_DATAFLOW_INSYNC_EN adds 2-flop input syncs. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module encoder_dataflow_sync #(
  parameter logic [1:0] IDLE_CODE = 2'b00
) (
  input wire clk,
  input wire rst,
  encoder_dataflow_sync_if.slave bus
);

  logic [2:0] req;

`ifdef ENCODER_DATAFLOW_INSYNC_EN
  // Two stages per line; each bit is synchronized independently.
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {bus.a, bus.b, bus.c};
      sync2_q <= sync1_q;
    end
  end

  assign req = sync2_q;
`else
  assign req = {bus.a, bus.b, bus.c};
`endif

  logic [1:0] outp_d;
  logic       valid_d;
  logic       multi_d;
  logic [1:0] outp_q;
  logic       valid_q;
  logic       multi_q;

  always_comb begin
    outp_d  = IDLE_CODE;
    if (req[2]) begin
      outp_d = 2'b11;
    end else if (req[1]) begin
      outp_d = 2'b10;
    end else if (req[0]) begin
      outp_d = 2'b01;
    end
    valid_d = |req;
    multi_d = (req[2] & req[1]) | (req[2] & req[0]) | (req[1] & req[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outp_q  <= IDLE_CODE;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      outp_q  <= outp_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign bus.outp  = outp_q;
  assign bus.valid = valid_q;
  assign bus.multi = multi_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder_dataflow_sync.sv
// +--------------------------------------------------------------------+
// | tb_encoder_dataflow_sync                                           |
// | Directed checks of the priority encoder, default and IDLE_CODE=10. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_encoder_dataflow_sync;

`ifdef ENCODER_DATAFLOW_INSYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // {outp, valid, multi} indexed by {a,b,c}
  localparam logic [3:0] EXP [8] = '{
    4'b0000, 4'b0110, 4'b1010, 4'b1011,
    4'b1110, 4'b1111, 4'b1111, 4'b1111
  };

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  encoder_dataflow_sync_if bus0 ();
  encoder_dataflow_sync_if bus1 ();

  encoder_dataflow_sync #(.IDLE_CODE(2'b00)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  encoder_dataflow_sync #(.IDLE_CODE(2'b10)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] abc);
    bus0.a = abc[2]; bus0.b = abc[1]; bus0.c = abc[0];
    bus1.a = abc[2]; bus1.b = abc[1]; bus1.c = abc[0];
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed outp/valid/multi=%b expected %b", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] obs0();
    return {bus0.outp, bus0.valid, bus0.multi};
  endfunction

  function automatic logic [3:0] obs1();
    return {bus1.outp, bus1.valid, bus1.multi};
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;

    rst = 1'b1;
    drive(3'b111);
    cyc(2);
    chk("reset_dut0", obs0(), 4'b0000);
    chk("reset_dut1", obs1(), 4'b1000);

    rst = 1'b0;
    cyc(LAT);
    chk("release_111", obs0(), 4'b1111);

    for (int i = 0; i < 8; i++) begin
      drive(3'(i));
      cyc(LAT);
      chk($sformatf("sweep_%0d", i), obs0(), EXP[i]);
    end

    drive(3'b011); cyc(LAT); chk("prio_011", obs0(), 4'b1011);
    drive(3'b101); cyc(LAT); chk("prio_101", obs0(), 4'b1111);
    drive(3'b001); cyc(LAT); chk("prio_001", obs0(), 4'b0110);

    drive(3'b100); cyc(LAT); chk("pre_rst_100", obs0(), 4'b1110);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst", obs0(), 4'b0000);
    rst = 1'b0;
    cyc(LAT);
    chk("post_rst_100", obs0(), 4'b1110);

    drive(3'b000); cyc(LAT); chk("idle10_000", obs1(), 4'b1000);
    drive(3'b010); cyc(LAT); chk("idle10_010", obs1(), 4'b1010);
    drive(3'b000); cyc(LAT); chk("idle00_000", obs0(), 4'b0000);

    drive(3'b010);
    cyc(LAT);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_%0d", k), obs0(), 4'b1010);
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
